fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage with the IF/ID pipeline register, directly upstream of the decode/hazard controller. Holds the PC, drives the instruction-memory address, selects the next PC from the controller's `PCSrc`/`Jmp`/`PCWrite` outputs, and registers the fetched instruction plus PC+4 into IF/ID. Implements stall (hold) and flush (bubble insert) so the controller's load-use and branch handling take effect cycle-accurately.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0000: instruction word inserted into IF/ID on flush or reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `PCWrite`  in  1  1 = PC may update this cycle; 0 = hold PC.
- `IF_IDWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- `PCSrc`  in  2  00 PC+4, 01 branch/jr, 10 jump/jal, 11 reserved (treated as 00).
- `Jmp`  in  1  with `PCSrc`=01 selects `jr_target` instead of `branch_target`.
- `branch_target`  in  32  beq target, computed in EX.
- `jr_target`  in  32  register value for jr (forwarded).
- `imem_addr`  out  32  equals current PC, combinational.
- `imem_rdata`  in  32  instruction at `imem_addr`, same-cycle (combinational memory).
- `if_id_inst`  out  32  registered instruction to controller `inst`.
- `if_id_pc4`  out  32  registered PC+4 of that instruction (jal link value).
- `if_id_valid`  out  1  0 = IF/ID holds a bubble.
- `stall_cnt`  out  16  stall-cycle counter (see Configuration).
- `flush_cnt`  out  16  redirect counter (see Configuration).

## Operation
- `pc4 = pc + 32'd4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Jump target `jt = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00}` (from decode-stage instruction).
- Next PC: `PCSrc`=00 or 11 → `pc4`; 01 & `Jmp`=0 → `branch_target`; 01 & `Jmp`=1 → `jr_target`; 10 → `jt`.
- `redirect = PCWrite & (PCSrc==01 | PCSrc==10)`.
- PC register: updates to next PC iff `PCWrite`=1, else holds.
- IF/ID register, priority order:
  1. `redirect`=1 → load `NOP_INST`, `if_id_pc4`=0, `if_id_valid`=0 (flush overrides `IF_IDWrite`=0).
  2. `IF_IDWrite`=0 → hold all three fields.
  3. else → load `imem_rdata`, `pc4`, `if_id_valid`=1.
- `PCWrite`=1 with `IF_IDWrite`=0 (illegal from controller): PC advances, IF/ID holds; instruction is dropped, no error flag.
- `PCWrite`=0 with `PCSrc`≠00: no redirect, no flush, PC holds.

## Timing
- Reset (async assert, `rst_n`=0): `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `if_id_inst`=`NOP_INST`, `if_id_pc4`=0, `if_id_valid`=0, `stall_cnt`=0, `flush_cnt`=0. Outputs change without a clock edge.
- Release: first edge with `rst_n`=1 loads the instruction at `RESET_PC` into IF/ID; `if_id_valid`=1 one cycle after release.
- Fetch latency: instruction appears on `if_id_inst` one clock after its PC is on `imem_addr`.
- Redirect: target on `imem_addr` the cycle after the redirect edge; target instruction in IF/ID two cycles after the redirect edge; exactly one bubble inserted.
- Stall: each cycle with `PCWrite`=0 & `IF_IDWrite`=0 holds PC and IF/ID; no bubble generated here (EX bubbling is downstream).
- Reset asserted mid-stall or mid-redirect: reset values win immediately; pending redirect is discarded.

## Configuration
- `FETCH_PERF_EN` defined: `stall_cnt` increments on every edge with `PCWrite`=0; `flush_cnt` increments on every edge with `redirect`=1; both saturate at 16'hFFFF; both cleared by reset only.
- Not defined: counter logic absent; `stall_cnt` and `flush_cnt` tied to 16'h0000.

## Test plan
- Reset then free-run, `PCSrc`=00, `PCWrite`=`IF_IDWrite`=1, memory word = address → `imem_addr` 0,4,8,…; `if_id_inst`=0x0000_0004 with `if_id_pc4`=8 in the second cycle after release.
- Two-cycle stall at PC=0x10 → `imem_addr` holds 0x10 for two cycles, `if_id_inst` unchanged; with macro `stall_cnt`=2.
- `PCSrc`=01, `Jmp`=0, `branch_target`=0x40 at PC=0x14 → next `imem_addr`=0x40, `if_id_valid`=0 one cycle, then `if_id_inst`=mem[0x40]; `flush_cnt`=1.
- `PCSrc`=01, `Jmp`=1, `jr_target`=0x80 → `imem_addr`=0x80; `PCSrc`=10 with `if_id_inst`=0x1800_0010, `if_id_pc4`=0x24 → `imem_addr`=0x40.
- Redirect with `IF_IDWrite`=0 → IF/ID flushed to `NOP_INST`; `PCSrc`=01 with `PCWrite`=0 → no flush, PC holds.
- `rst_n` pulsed low mid-stall at PC=0x30 → `imem_addr`=`RESET_PC` before next edge; PC=0xFFFF_FFFC free-run → wraps to 0x0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: controller/memory/decode-facing signals of the fetch stage
interface fetch_if;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic [1:0]  PCSrc;
  logic        Jmp;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  modport master (
    output PCWrite, IF_IDWrite, PCSrc, Jmp, branch_target, jr_target, imem_rdata,
    input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );
  modport slave (
    input  PCWrite, IF_IDWrite, PCSrc, Jmp, branch_target, jr_target, imem_rdata,
    output imem_addr, if_id_inst, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC and IF/ID register with stall/flush; define FETCH_PERF_EN for stall/flush counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  fetch_if.slave bus
);
  logic [31:0] pc, pc4, jt, next_pc;
  logic redirect;
  assign pc4 = pc + 32'd4;
  assign jt = {bus.if_id_pc4[31:28], bus.if_id_inst[25:0], 2'b00};
  assign redirect = bus.PCWrite & (bus.PCSrc == 2'b01 | bus.PCSrc == 2'b10);
  assign bus.imem_addr = pc;
  always_comb begin
    next_pc = pc4;
    next_pc = bus.PCSrc == 2'b01 ? (bus.Jmp ? bus.jr_target : bus.branch_target) :
              bus.PCSrc == 2'b10 ? jt : pc4;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (bus.PCWrite) pc <= next_pc;
  // a redirect flushes IF/ID even when the controller asks it to hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.if_id_inst  <= NOP_INST;
      bus.if_id_pc4   <= 32'd0;
      bus.if_id_valid <= 1'b0;
    end else if (redirect) begin
      bus.if_id_inst  <= NOP_INST;
      bus.if_id_pc4   <= 32'd0;
      bus.if_id_valid <= 1'b0;
    end else if (bus.IF_IDWrite) begin
      bus.if_id_inst  <= bus.imem_rdata;
      bus.if_id_pc4   <= pc4;
      bus.if_id_valid <= 1'b1;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.stall_cnt <= 16'h0;
      bus.flush_cnt <= 16'h0;
    end else begin
      if (!bus.PCWrite && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
      if (redirect && bus.flush_cnt != 16'hFFFF) bus.flush_cnt <= bus.flush_cnt + 16'd1;
    end
`else
  assign bus.stall_cnt = 16'h0;
  assign bus.flush_cnt = 16'h0;
`endif
endmodule
